csi2tx_reset_seq: RTL and testbench

Parametrised reset sequencer for the CSI-2 TX core, operating in the `clk_csi` domain. It holds a configurable number of downstream channel resets for a guaranteed minimum width, then releases them one at a time in ascending index order with a fixed gap between releases. It also accepts an asynchronous software reset request through a 4-phase handshake and provides a test-mode bypass. It replaces the fixed two-flop, release-all-at-once reset scheme for blocks that need ordered reset release.

---
 rtl/csi2tx_reset_seq.sv | 172 +++++++++++++++++
 tb/tb_csi2tx_reset_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/csi2tx_reset_seq.sv
// csi2tx_reset_seq
// Ordered reset sequencer for the CSI-2 TX core (clk_csi domain).
// Holds all channel resets for MIN_ASSERT cycles, then releases them one at
// a time in ascending index order, GAP_CYCLES apart. An asynchronous software
// reset request (4-phase level handshake) restarts the sequence; test_mode
// drives all channel resets straight from pwr_on_rst.
//
// Ports:
//   clk_csi     in   clock
//   pwr_on_rst  in   synchronous active-high reset
//   test_mode   in   scan bypass: ch_rst_n = ~pwr_on_rst on every channel
//   sw_rst_req  in   asynchronous software reset request (level)
//   sw_rst_ack  out  acknowledge for sw_rst_req
//   ch_rst_n    out  active-low channel resets [NUM_CH-1:0]
//   rst_busy    out  high while holding or releasing
//   seq_done    out  high once every channel is released
module csi2tx_reset_seq #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_ASSERT  = 16,
  parameter int GAP_CYCLES  = 4
) (
  input  logic              clk_csi,
  input  logic              pwr_on_rst,
  input  logic              test_mode,
  input  logic              sw_rst_req,
  output logic              sw_rst_ack,
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic              rst_busy,
  output logic              seq_done
);

  localparam int CNT_MAX = (MIN_ASSERT > GAP_CYCLES) ? MIN_ASSERT : GAP_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(MIN_ASSERT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NUM_CH-1:0]      ch_q, ch_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_d_q;
  logic                   pend_q, pend_d;
  logic                   ack_q, ack_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   req_s;
  logic                   trigger;
  logic                   enter_run;

  assign req_s   = sync_q[SYNC_STAGES-1];
  assign trigger = req_s & ~req_d_q;

  // State register: FSM state, counters, synchroniser and registered outputs.
  always_ff @(posedge clk_csi) begin
    if (pwr_on_rst) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      ch_q    <= '0;
      sync_q  <= '0;
      req_d_q <= 1'b0;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ch_q    <= ch_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sw_rst_req};
      req_d_q <= req_s;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. A trigger overrides whatever the sequence was doing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ch_d    = ch_q;
    if (trigger) begin
      state_d = HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      ch_d    = '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            ch_d[0] = 1'b1;
            cnt_d   = '0;
            if (NUM_CH == 1) begin
              state_d = RUN;
            end else begin
              idx_d   = IW'(1);
              state_d = RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
              if (IW'(i) == idx_q) ch_d[i] = 1'b1;
            end
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = RUN;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RUN: begin
          ch_d = '1;
        end
        default: begin
          state_d = HOLD;
          cnt_d   = '0;
          idx_d   = '0;
          ch_d    = '0;
        end
      endcase
    end
  end

  // Output logic. Ack is set on RUN entry for a software-initiated sequence;
  // the set wins over the clear so a request already withdrawn still sees a
  // one-cycle ack pulse.
  always_comb begin
    enter_run = (state_d == RUN) && (state_q != RUN);
    pend_d    = pend_q;
    ack_d     = ack_q;
    if (trigger) begin
      pend_d = 1'b1;
    end else if (enter_run) begin
      pend_d = 1'b0;
    end
    if (enter_run && pend_q) begin
      ack_d = 1'b1;
    end else if (!req_s) begin
      ack_d = 1'b0;
    end
    busy_d = (state_d != RUN);
    done_d = (state_d == RUN);
    ch_rst_n   = test_mode ? {NUM_CH{~pwr_on_rst}} : ch_q;
    sw_rst_ack = ack_q;
    rst_busy   = busy_q;
    seq_done   = done_q;
  end

endmodule

// File: tb/tb_csi2tx_reset_seq.sv
// Bench for csi2tx_reset_seq: default-parameter instance checked every cycle
// against a timing model (channel k is out of reset once MIN + k*GAP edges
// have elapsed since the sequence started), plus a NUM_CH=1 instance with
// directed latency checks.
module tb_csi2tx_reset_seq;

  localparam int N      = 4;
  localparam int MIN    = 16;
  localparam int GAP    = 4;
  localparam int SYNC   = 2;
  localparam int DONE_T = MIN + (N - 1) * GAP;

  logic         clk = 1'b0;
  logic         por, tm, req;
  logic         ack, busy, done;
  logic [N-1:0] ch;

  logic         por1, req1, tm1;
  logic         ack1, busy1, done1;
  logic [0:0]   ch1;

  int checks   = 0;
  int failures = 0;

  // model state
  int   m_t;
  logic m_q[$];
  logic m_req_d, m_pend, m_ack;

  always #5 clk = ~clk;

  csi2tx_reset_seq dut (
    .clk_csi   (clk),
    .pwr_on_rst(por),
    .test_mode (tm),
    .sw_rst_req(req),
    .sw_rst_ack(ack),
    .ch_rst_n  (ch),
    .rst_busy  (busy),
    .seq_done  (done)
  );

  csi2tx_reset_seq #(
    .NUM_CH     (1),
    .SYNC_STAGES(3),
    .MIN_ASSERT (1),
    .GAP_CYCLES (1)
  ) dut1 (
    .clk_csi   (clk),
    .pwr_on_rst(por1),
    .test_mode (tm1),
    .sw_rst_req(req1),
    .sw_rst_ack(ack1),
    .ch_rst_n  (ch1),
    .rst_busy  (busy1),
    .seq_done  (done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model update for one clock edge using the inputs the DUT sampled.
  task automatic model_edge();
    logic rs, trig;
    rs   = m_q[0];
    trig = rs && !m_req_d;
    if (por) begin
      m_t = 0;
      for (int i = 0; i < SYNC; i++) m_q[i] = 1'b0;
      m_req_d = 1'b0;
      m_pend  = 1'b0;
      m_ack   = 1'b0;
    end else begin
      if (trig) begin
        m_t    = 0;
        m_pend = 1'b1;
        if (!rs) m_ack = 1'b0;
      end else begin
        if (m_t < 100000) m_t++;
        if (m_t == DONE_T && m_pend) begin
          m_ack  = 1'b1;
          m_pend = 1'b0;
        end else if (!rs) begin
          m_ack = 1'b0;
        end
      end
      m_q.push_back(req);
      void'(m_q.pop_front());
      m_req_d = rs;
    end
  endtask

  function automatic logic [N-1:0] m_ch();
    logic [N-1:0] e;
    for (int k = 0; k < N; k++) e[k] = (m_t >= MIN + k * GAP);
    if (tm) e = {N{~por}};
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("ch_rst_n", 32'(ch), 32'(m_ch()));
    chk("sw_rst_ack", 32'(ack), 32'(m_ack));
    chk("rst_busy", 32'(busy), 32'(m_t < DONE_T));
    chk("seq_done", 32'(done), 32'(m_t >= DONE_T));
  endtask

  task automatic wait_ack();
    for (int i = 0; i < 200 && !m_ack; i++) tick();
    chk("ack_arrives", 32'(ack), 32'd1);
  endtask

  initial begin
    por = 1'b1; tm = 1'b0; req = 1'b0;
    por1 = 1'b1; tm1 = 1'b0; req1 = 1'b0;
    m_t = 0; m_req_d = 1'b0; m_pend = 1'b0; m_ack = 1'b0;
    for (int i = 0; i < SYNC; i++) m_q.push_back(1'b0);

    // reset state
    repeat (3) tick();
    chk("reset_ch", 32'(ch), 32'd0);
    chk("reset_busy", 32'(busy), 32'd1);

    // power-on sequence
    por = 1'b0;
    repeat (15) tick();
    chk("po_edge15", 32'(ch), 32'h0);
    tick();
    chk("po_edge16", 32'(ch), 32'h1);
    repeat (12) tick();
    chk("po_edge28", 32'(ch), 32'hF);
    chk("po_no_ack", 32'(ack), 32'd0);
    chk("po_done", 32'(done), 32'd1);

    // software handshake from RUN
    req = 1'b1;
    repeat (3) tick();
    chk("sw_lat_ch", 32'(ch), 32'h0);
    wait_ack();
    req = 1'b0;
    repeat (2) tick();
    chk("sw_ack_hold", 32'(ack), 32'd1);
    tick();
    chk("sw_ack_fall", 32'(ack), 32'd0);

    // short request dropped before ack, then abort at 0011
    req = 1'b1;
    repeat (3) tick();
    req = 1'b0;
    for (int i = 0; i < 100 && m_t != 19; i++) tick();
    chk("abort_reach", 32'(m_t), 32'd19);
    req = 1'b1;
    repeat (2) tick();
    chk("abort_pre", 32'(ch), 32'h3);
    tick();
    chk("abort_ch", 32'(ch), 32'h0);
    repeat (15) tick();
    chk("abort_hold", 32'(ch), 32'h0);
    tick();
    chk("abort_rel0", 32'(ch), 32'h1);
    wait_ack();
    req = 1'b0;
    repeat (3) tick();
    chk("abort_ack_fall", 32'(ack), 32'd0);

    // mid-sequence power-on reset discards pending ack
    req = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 0; i < 100 && m_t != 24; i++) tick();
    chk("por_mid_pre", 32'(ch), 32'h7);
    por = 1'b1;
    tick();
    chk("por_mid_ch", 32'(ch), 32'h0);
    chk("por_mid_busy", 32'(busy), 32'd1);
    por = 1'b0;
    repeat (40) tick();
    chk("por_mid_no_ack", 32'(ack), 32'd0);

    // test-mode combinational bypass
    tm = 1'b1;
    for (int i = 0; i < 4; i++) begin
      por = (i % 2 == 0);
      #1;
      chk("tm_comb", 32'(ch), 32'(por ? 4'h0 : 4'hF));
    end
    por = 1'b1;
    tm  = 1'b0;
    tick();
    por = 1'b0;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) req = ~req;
      por = ($urandom_range(79) == 0);
      tm  = ($urandom_range(19) == 0);
      tick();
    end
    por = 1'b0; tm = 1'b0; req = 1'b0;

    // NUM_CH=1, MIN=1, GAP=1, SYNC=3 instance
    tick();
    por1 = 1'b0;
    tick();
    chk("n1_edge1_ch", 32'(ch1), 32'd1);
    chk("n1_edge1_done", 32'(done1), 32'd1);
    chk("n1_no_ack", 32'(ack1), 32'd0);
    req1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("n1_lat_wait", 32'(ch1), 32'd1);
    end
    tick();
    chk("n1_lat_ch", 32'(ch1), 32'd0);
    chk("n1_lat_busy", 32'(busy1), 32'd1);
    tick();
    chk("n1_rerel_ch", 32'(ch1), 32'd1);
    chk("n1_ack", 32'(ack1), 32'd1);
    req1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("n1_ack_hold", 32'(ack1), 32'd1);
    end
    tick();
    chk("n1_ack_fall", 32'(ack1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
